// File: rtl/ysyx22041405_imem.sv
// Instruction memory with a request/response handshake and fixed access latency.
// A separate load port writes program words at any time, including during reset.
module ysyx22041405_imem #(
    parameter int unsigned      WIDTH   = 32,
    parameter int unsigned      DEPTH   = 256,
    parameter int unsigned      LATENCY = 2,
    parameter logic [WIDTH-1:0] BASE    = 32'h8000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [WIDTH-1:0]         req_addr,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [WIDTH-1:0]         resp_inst,
    output logic                     resp_err,
    input  logic                     ld_en,
    input  logic [$clog2(DEPTH)-1:0] ld_addr,
    input  logic [WIDTH-1:0]         ld_data
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [3:0]  CNT_INIT = 4'((LATENCY >= 2) ? (LATENCY - 2) : 0);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t           state;
    logic [3:0]       cnt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] offset;
    logic [WIDTH-1:0] rd_word;
    logic [WIDTH-1:0] pend_inst;
    logic             pend_err;
    logic             fault;
    logic [AW-1:0]    idx;

    // The offset check catches addresses past the end; the explicit compare catches wrap-around.
    assign offset  = req_addr - BASE;
    assign idx     = offset[AW+1:2];
    assign fault   = (req_addr[1:0] != 2'b00) || (req_addr < BASE) ||
                     ((offset >> (AW + 2)) != '0);
    assign rd_word = fault ? '0 : mem[idx];

    // Not reset: program contents survive a reset and loads proceed during one.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_inst  <= '0;
            resp_err   <= 1'b0;
            pend_inst  <= '0;
            pend_err   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        // Word is captured here so later loads cannot alter this response.
                        pend_inst <= rd_word;
                        pend_err  <= fault;
                        req_ready <= 1'b0;
                        if (LATENCY == 1) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_inst  <= rd_word;
                            resp_err   <= fault;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_inst  <= pend_inst;
                        resp_err   <= pend_err;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        req_ready  <= 1'b1;
                        resp_valid <= 1'b0;
                        resp_inst  <= '0;
                        resp_err   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx22041405_imem.sv
// Randomized scoreboard bench for ysyx22041405_imem: a driver pushes expected responses,
// a negedge monitor pops and compares them; a second LATENCY=1 instance checks back-to-back rate.
module tb_ysyx22041405_imem;

    localparam int unsigned LATENCY = 2;
    localparam int unsigned DEPTH   = 256;
    localparam logic [31:0] BASE    = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_ready, resp_valid, resp_ready = 1'b0, resp_err;
    logic [31:0] req_addr = '0, resp_inst;
    logic        ld_en = 1'b0;
    logic [7:0]  ld_addr = '0;
    logic [31:0] ld_data = '0;
    logic        r1_req_valid = 1'b0, r1_req_ready, r1_resp_valid, r1_resp_ready = 1'b0;
    logic        r1_resp_err;
    logic [31:0] r1_req_addr = '0, r1_resp_inst;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    bit mon_on = 1'b0;

    typedef struct {
        logic [31:0] inst;
        logic        err;
        int          acc;
    } exp_t;
    exp_t        exp_q[$];
    logic [31:0] ref_mem[DEPTH];

    ysyx22041405_imem #(.WIDTH(32), .DEPTH(DEPTH), .LATENCY(LATENCY), .BASE(BASE)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_inst(resp_inst), .resp_err(resp_err), .ld_en(ld_en), .ld_addr(ld_addr),
        .ld_data(ld_data)
    );

    ysyx22041405_imem #(.WIDTH(32), .DEPTH(DEPTH), .LATENCY(1), .BASE(BASE)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(r1_req_valid), .req_ready(r1_req_ready),
        .req_addr(r1_req_addr), .resp_valid(r1_resp_valid), .resp_ready(r1_resp_ready),
        .resp_inst(r1_resp_inst), .resp_err(r1_resp_err), .ld_en(ld_en), .ld_addr(ld_addr),
        .ld_data(ld_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: fault rules and word lookup straight from the address map.
    function automatic bit is_fault(input logic [31:0] a);
        longint unsigned la;
        la = a;
        return (a[1:0] != 2'b00) || (la < BASE) || (la >= longint'(BASE) + 4 * DEPTH);
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'((a - BASE) >> 2) % DEPTH;
    endfunction

    task automatic load(input int i, input logic [31:0] d);
        ld_en = 1'b1; ld_addr = 8'(i); ld_data = d;
        tick();
        ld_en = 1'b0;
        ref_mem[i] = d;
    endtask

    task automatic scramble_req();
        req_valid = 1'($urandom);
        req_addr  = $urandom;
    endtask

    task automatic fetch(input logic [31:0] addr, input int stall, input bit do_ld,
                         input int li, input logic [31:0] ld_d, input bit abort);
        exp_t e;
        int   n;
        req_valid = 1'b1;
        req_addr  = addr;
        n = 0;
        while (!req_ready && n < 50) begin tick(); n++; end
        if (!req_ready) begin
            fail_now("req_ready_timeout");
            req_valid = 1'b0;
            return;
        end
        e.err  = is_fault(addr);
        e.inst = e.err ? 32'h0 : ref_mem[idx_of(addr)];
        if (do_ld) begin ld_en = 1'b1; ld_addr = 8'(li); ld_data = ld_d; end
        tick();
        ld_en = 1'b0;
        if (do_ld) ref_mem[li] = ld_d;
        e.acc = cyc;
        if (abort) begin
            // Reset in WAIT with a valid request and a load presented on the reset edge.
            rst = 1'b1; req_valid = 1'b1; req_addr = BASE;
            ld_en = 1'b1; ld_addr = 8'd200; ld_data = 32'h1234_5678;
            tick();
            rst = 1'b0; req_valid = 1'b0; ld_en = 1'b0;
            ref_mem[200] = 32'h1234_5678;
            chk("abort_req_ready", req_ready, 1);
            chk("abort_resp_valid", resp_valid, 0);
            repeat (3) begin
                tick();
                chk("abort_no_resp", resp_valid, 0);
            end
            return;
        end
        exp_q.push_back(e);
        scramble_req();
        n = 0;
        while (!resp_valid && n < 50) begin tick(); scramble_req(); n++; end
        if (!resp_valid) fail_now("resp_valid_timeout");
        repeat (stall) begin
            tick();
            scramble_req();
            chk("stall_req_ready", req_ready, 0);
        end
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        req_addr   = BASE;
        tick();
        resp_ready = 1'b0;
        chk("idle_after_resp", {req_ready, resp_valid}, 2'b10);
        req_valid = 1'b0;
    endtask

    // Monitor: compares every handshake against the queue, checks hold and idle-zero rules.
    logic        prev_valid = 1'b0, prev_ready = 1'b0;
    logic [32:0] prev_out = '0;
    always @(negedge clk) begin
        if (mon_on) begin
            if (resp_valid) begin
                chk("resp_req_ready", req_ready, 0);
                if (!prev_valid) begin
                    if (exp_q.size() == 0) fail_now("unexpected_resp_valid");
                    else chk("latency", 64'(cyc - exp_q[0].acc), 64'(LATENCY - 1));
                end else if (!prev_ready) begin
                    chk("hold_stable", {resp_err, resp_inst}, prev_out);
                end
                if (resp_ready) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_handshake");
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("resp_inst", resp_inst, e.inst);
                        chk("resp_err", resp_err, e.err);
                    end
                end
            end else begin
                chk("idle_zero", {resp_err, resp_inst}, 33'h0);
            end
            prev_valid = resp_valid;
            prev_ready = resp_ready;
            prev_out   = {resp_err, resp_inst};
        end
    end

    initial begin
        logic [31:0] a;
        // Load during reset must still take effect.
        ld_en = 1'b1; ld_addr = 8'd0; ld_data = 32'h0000_0413;
        tick();
        ld_en = 1'b0;
        ref_mem[0] = 32'h0000_0413;
        tick();
        rst = 1'b0;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_out", {resp_err, resp_inst}, 33'h0);
        chk("rst_r1_ready", r1_req_ready, 1);
        mon_on = 1'b1;

        load(1, 32'h0010_0093);
        for (int i = 2; i < DEPTH; i++) load(i, $urandom);

        fetch(32'h8000_0004, 0, 0, 0, 0, 0);
        fetch(32'h8000_0002, 0, 0, 0, 0, 0);
        fetch(32'h7FFF_FFFC, 1, 0, 0, 0, 0);
        fetch(32'h8000_0400, 0, 0, 0, 0, 0);
        fetch(32'h8000_0008, 5, 0, 0, 0, 0);
        fetch(32'h8000_0000, 0, 1, 0, 32'hDEAD_BEEF, 0);
        fetch(32'h8000_0000, 0, 0, 0, 0, 0);
        fetch(32'h8000_0010, 0, 0, 0, 0, 1);
        fetch(32'h8000_0010, 0, 0, 0, 0, 0);
        fetch(BASE + 32'd800, 0, 0, 0, 0, 0);

        for (int t = 0; t < 60; t++) begin
            case ($urandom_range(0, 3))
                0, 1: a = BASE + 4 * $urandom_range(0, DEPTH - 1);
                2:    a = BASE + 4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3);
                default: a = ($urandom_range(0, 1) == 1) ? BASE - 4 * $urandom_range(1, 1000)
                                                         : BASE + 4 * DEPTH + 4 * $urandom_range(0, 1000);
            endcase
            if ($urandom_range(0, 3) == 0) load($urandom_range(0, DEPTH - 1), $urandom);
            fetch(a, $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, DEPTH - 1),
                  $urandom, 0);
        end
        chk("queue_drained", exp_q.size(), 0);

        // LATENCY=1 instance: accept on every other edge with both valids held high.
        r1_req_valid = 1'b1; r1_req_addr = BASE + 32'd8; r1_resp_ready = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk("r1_resp_valid", r1_resp_valid, k % 2);
            chk("r1_req_ready", r1_req_ready, (k + 1) % 2);
            chk("r1_resp_out", {r1_resp_err, r1_resp_inst},
                (k % 2 == 1) ? {1'b0, ref_mem[2]} : 33'h0);
        end
        r1_req_valid = 1'b0;
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
